rho_inv_unit: RTL and testbench

//  Multi-cycle inverse Keccak rho. Each 64-bit lane is rotated RIGHT by its fixed rho offset, which undoes the rho step.
//  The block sits on the inverse-permutation and debug path of the engine.

---
 rtl/rho_inv_unit.sv | 120 ++++++++++++
 tb/tb_rho_inv_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rho_inv_unit.sv
// Inverse Keccak rho: rotates every 64-bit lane right by its rho offset,
// LANES_PER_CYCLE lanes per cycle, through a 25-lane buffer with valid/ready on each side.
module rho_inv_unit #(
  parameter int LANES_PER_CYCLE = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0][4:0][63:0] in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0][4:0][63:0] out_state,
  output logic                  busy
);

  localparam int ROW_SIZE  = 5;
  localparam int COL_SIZE  = 5;
  localparam int LANE_SIZE = 64;
  localparam int NUM_LANES = ROW_SIZE * COL_SIZE;
  localparam int N         = NUM_LANES / LANES_PER_CYCLE;
  localparam int CW        = (N > 1) ? $clog2(N) : 1;

  if (LANES_PER_CYCLE != 1 && LANES_PER_CYCLE != 5 && LANES_PER_CYCLE != 25) begin : g_bad_lpc
    $error("rho_inv_unit: LANES_PER_CYCLE must be 1, 5 or 25");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                                state_q, state_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [NUM_LANES-1:0][LANE_SIZE-1:0]   lane_buf_q, lane_buf_d;

  // Rho offsets addressed by linear lane index i = 5*x + y.
  function automatic logic [5:0] rho_off(input int i);
    case (i)
      0:  return 6'd0;   1:  return 6'd36;  2:  return 6'd3;   3:  return 6'd41;  4:  return 6'd18;
      5:  return 6'd1;   6:  return 6'd44;  7:  return 6'd10;  8:  return 6'd45;  9:  return 6'd2;
      10: return 6'd62;  11: return 6'd6;   12: return 6'd43;  13: return 6'd15;  14: return 6'd61;
      15: return 6'd28;  16: return 6'd55;  17: return 6'd25;  18: return 6'd21;  19: return 6'd56;
      20: return 6'd27;  21: return 6'd20;  22: return 6'd39;  23: return 6'd8;   24: return 6'd14;
      default: return 6'd0;
    endcase
  endfunction

  // Shifting the doubled lane keeps every shift amount below 64, so offset 0 is safe.
  function automatic logic [LANE_SIZE-1:0] rotr(input logic [LANE_SIZE-1:0] v, input logic [5:0] s);
    logic [2*LANE_SIZE-1:0] w;
    w = {v, v} >> s;
    return w[LANE_SIZE-1:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_buf_d = lane_buf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int x = 0; x < ROW_SIZE; x++) begin
            for (int y = 0; y < COL_SIZE; y++) begin
              lane_buf_d[COL_SIZE*x + y] = in_state[x][y];
            end
          end
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < LANES_PER_CYCLE; j++) begin
          lane_buf_d[int'(cnt_q)*LANES_PER_CYCLE + j] =
            rotr(lane_buf_q[int'(cnt_q)*LANES_PER_CYCLE + j],
                 rho_off(int'(cnt_q)*LANES_PER_CYCLE + j));
        end
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lane_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_buf_q <= lane_buf_d;
    end
  end

  // Handshake outputs decode the state register only; out_state is masked outside DONE.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_state = '0;
    for (int x = 0; x < ROW_SIZE; x++) begin
      for (int y = 0; y < COL_SIZE; y++) begin
        out_state[x][y] = (state_q == DONE) ? lane_buf_q[COL_SIZE*x + y] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rho_inv_unit.sv
// Self-checking bench for rho_inv_unit: one instance each for 1, 5 and 25 lanes per cycle,
// table-driven single-lane vectors, forward-rho round trips and hand-written corner sequences.
module tb_rho_inv_unit;

  typedef logic [4:0][4:0][63:0] state_t;

  typedef struct {
    int          g;
    int          ix;
    int          iy;
    logic [63:0] in_val;
    int          ex;
    int          ey;
    logic [63:0] exp_val;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t in_state;
  logic   in_valid  [3];
  logic   out_ready [3];
  logic   in_ready  [3];
  logic   out_valid [3];
  logic   busy      [3];
  state_t out_state [3];

  int     errors = 0;
  int     checks = 0;
  state_t exp_q[$];

  int exp_lat_tab [3] = '{26, 6, 2};
  int off_tab [5][5] = '{'{0, 36, 3, 41, 18},
                         '{1, 44, 10, 45, 2},
                         '{62, 6, 43, 15, 61},
                         '{28, 55, 25, 21, 56},
                         '{27, 20, 39, 8, 14}};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rho_inv_unit #(
      .LANES_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 5 : 25))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_state (in_state),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_state(out_state[g]),
      .busy     (busy[g])
    );
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_state(input string name, input state_t act, input state_t req);
    bit shown;
    checks++;
    if (act !== req) begin
      errors++;
      shown = 1'b0;
      for (int x = 0; x < 5; x++) begin
        for (int y = 0; y < 5; y++) begin
          if (!shown && act[x][y] !== req[x][y]) begin
            $display("[TB] FAIL %s: lane[%0d][%0d] got %h, expected %h", name, x, y, act[x][y], req[x][y]);
            shown = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    if (n == 0) return v;
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic state_t rho_fwd(input state_t s);
    state_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = rotl(s[x][y], off_tab[x][y]);
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  // One full transaction; stray in_valid pulses with a different state are driven while busy.
  task automatic apply_stimulus(input int g, input state_t s, input state_t e, input int hold, input string name);
    int     lat;
    state_t want;
    exp_q.push_back(e);
    out_ready[g] = (hold == 0);
    in_state     = s;
    in_valid[g]  = 1'b1;
    check_output({name, " in_ready"}, 64'(in_ready[g]), 64'd1);
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
    lat = 1;
    while (!out_valid[g] && lat < 40) begin
      in_valid[g] = lat[0];
      in_state    = ~s;
      @(posedge clk); #1;
      lat++;
    end
    in_valid[g] = 1'b0;
    check_output({name, " latency"}, 64'(lat), 64'(exp_lat_tab[g]));
    want = exp_q.pop_front();
    check_state({name, " out_state"}, out_state[g], want);
    for (int h = 0; h < hold; h++) begin
      in_valid[g] = 1'b1;
      in_state    = rand_state();
      @(posedge clk); #1;
      check_output({name, " hold out_valid"}, 64'(out_valid[g]), 64'd1);
      check_output({name, " hold in_ready"}, 64'(in_ready[g]), 64'd0);
      check_state({name, " hold out_state"}, out_state[g], want);
    end
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b1;
    @(posedge clk); #1;
    check_output({name, " out_valid drop"}, 64'(out_valid[g]), 64'd0);
  endtask

  initial begin
    vec_t   vecs [8];
    state_t s;
    state_t e;

    rst_n    = 1'b0;
    in_state = '0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int g = 0; g < 3; g++) begin
      check_output($sformatf("reset in_ready g%0d", g), 64'(in_ready[g]), 64'd1);
      check_output($sformatf("reset out_valid g%0d", g), 64'(out_valid[g]), 64'd0);
      check_output($sformatf("reset busy g%0d", g), 64'(busy[g]), 64'd0);
      check_state($sformatf("reset out_state g%0d", g), out_state[g], '0);
    end

    vecs[0] = '{1, 1, 0, 64'h1,                   1, 0, 64'h8000_0000_0000_0000};
    vecs[1] = '{1, 0, 0, 64'hDEAD_BEEF_0123_4567, 0, 0, 64'hDEAD_BEEF_0123_4567};
    vecs[2] = '{1, 4, 3, 64'h100,                 4, 3, 64'h1};
    vecs[3] = '{0, 2, 0, 64'h1,                   2, 0, 64'h4};
    vecs[4] = '{2, 3, 1, 64'h0080_0000_0000_0000, 3, 1, 64'h1};
    vecs[5] = '{0, 0, 1, 64'h0000_0010_0000_0000, 0, 1, 64'h1};
    vecs[6] = '{2, 4, 4, 64'h1,                   4, 4, 64'h0004_0000_0000_0000};
    vecs[7] = '{1, 2, 4, 64'hF,                   2, 4, 64'h78};

    for (int v = 0; v < 8; v++) begin
      s = '0;
      e = '0;
      s[vecs[v].ix][vecs[v].iy] = vecs[v].in_val;
      e[vecs[v].ex][vecs[v].ey] = vecs[v].exp_val;
      apply_stimulus(vecs[v].g, s, e, 0, $sformatf("vec%0d", v));
    end

    s = '0;
    e = '0;
    s[0][0] = 64'hDEAD_BEEF_0123_4567;
    s[4][3] = 64'h100;
    e[0][0] = 64'hDEAD_BEEF_0123_4567;
    e[4][3] = 64'h1;
    apply_stimulus(1, s, e, 0, "two lanes");

    for (int g = 0; g < 3; g++) begin
      for (int n = 0; n < 100; n++) begin
        e = rand_state();
        apply_stimulus(g, rho_fwd(e), e, 0, $sformatf("roundtrip g%0d n%0d", g, n));
      end
    end

    e = rand_state();
    apply_stimulus(1, rho_fwd(e), e, 10, "backpressure");

    // Reset while three lane groups are still unrotated.
    e = rand_state();
    in_state    = rho_fwd(e);
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_output("midbusy out_valid", 64'(out_valid[1]), 64'd0);
    check_output("midbusy busy", 64'(busy[1]), 64'd0);
    check_output("midbusy in_ready", 64'(in_ready[1]), 64'd1);
    check_state("midbusy out_state", out_state[1], '0);
    apply_stimulus(1, rho_fwd(e), e, 0, "after reset");

    rst_n       = 1'b0;
    in_valid[2] = 1'b1;
    in_state    = rand_state();
    @(posedge clk); #1;
    rst_n       = 1'b1;
    in_valid[2] = 1'b0;
    check_output("reset wins busy", 64'(busy[2]), 64'd0);
    @(posedge clk); #1;
    check_output("reset wins no capture", 64'(busy[2]), 64'd0);
    check_output("reset wins out_valid", 64'(out_valid[2]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
